// File: rtl/mk_tlul2axi_sync_tgl_rx.sv
// mk_tlul2axi_sync_tgl_rx
// Receive side of a toggle-handshake clock-domain crossing. The request toggle
// arrives already synchronized into clk. Each toggle edge captures the
// bundled payload and presents it as a valid/ready transfer. The acknowledge
// toggle is inverted when the local consumer takes the data.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active high
//   req_tgl_sync - synchronized request toggle
//   req_data     - bundled payload, held stable by the source while outstanding
//   out_valid    - transfer valid (high exactly while holding a captured word)
//   out_ready    - consumer ready
//   out_data     - captured payload
//   ack_tgl      - acknowledge toggle back to the source domain
//   proto_err    - sticky: a new request arrived while one was still held
//   err_clr      - clears proto_err (a coincident set takes priority)
//   xfer_cnt     - completed transfers, wraps modulo 256
module mk_tlul2axi_sync_tgl_rx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_tgl_sync,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ack_tgl,
    output logic                  proto_err,
    input  logic                  err_clr,
    output logic [7:0]            xfer_cnt
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t state, state_nxt;
    logic   req_prev;
    logic   edge_det;
    logic   capture;
    logic   xfer_done;
    logic   err_set;

    assign edge_det = req_tgl_sync ^ req_prev;

    // out_valid is a direct decode of the single-bit state flop.
    assign out_valid = (state == HOLD);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        xfer_done = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // An edge here is not consumed: req_prev stays put, so the
                // request is still seen as pending on the next IDLE cycle.
                err_set = edge_det;
                if (out_ready) begin
                    xfer_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_prev  <= 1'b0;
            out_data  <= '0;
            ack_tgl   <= 1'b0;
            proto_err <= 1'b0;
            xfer_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                req_prev <= req_tgl_sync;
                out_data <= req_data;
            end
            if (xfer_done) begin
                ack_tgl  <= ~ack_tgl;
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            if (err_set)
                proto_err <= 1'b1;
            else if (err_clr)
                proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mk_tlul2axi_sync_tgl_rx.sv
// Directed bench for mk_tlul2axi_sync_tgl_rx. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, i.e. they show the
// result of the edge just taken.
module tb_mk_tlul2axi_sync_tgl_rx;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_tgl_sync;
    logic [DW-1:0] req_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ack_tgl;
    logic          proto_err;
    logic          err_clr;
    logic [7:0]    xfer_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mk_tlul2axi_sync_tgl_rx #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_tgl_sync (req_tgl_sync),
        .req_data     (req_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ack_tgl      (ack_tgl),
        .proto_err    (proto_err),
        .err_clr      (err_clr),
        .xfer_cnt     (xfer_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic a, input logic e, input logic [7:0] c);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".ack"},   64'(ack_tgl),   64'(a));
        chk({tag, ".err"},   64'(proto_err), 64'(e));
        chk({tag, ".cnt"},   64'(xfer_cnt),  64'(c));
    endtask

    initial begin
        logic tg;
        reset        = 1'b1;
        req_tgl_sync = 1'b0;
        req_data     = '0;
        out_ready    = 1'b0;
        err_clr      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);

        // Basic transfer.
        tick();
        tick();
        req_data     = 32'hA5A5_0001;
        out_ready    = 1'b1;
        req_tgl_sync = 1'b1;
        tick();
        chk_all("basic_hold", 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 8'd0);
        tick();
        chk_all("basic_done", 1'b0, 32'hA5A5_0001, 1'b1, 1'b0, 8'd1);

        // Backpressure: payload changes at the source must not leak through.
        out_ready    = 1'b0;
        req_data     = 32'h0000_0033;
        req_tgl_sync = 1'b0;
        tick();
        chk_all("bp_capture", 1'b1, 32'h33, 1'b1, 1'b0, 8'd1);
        req_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("bp_stall", 1'b1, 32'h33, 1'b1, 1'b0, 8'd1);
        end
        out_ready = 1'b1;
        tick();
        chk_all("bp_release", 1'b0, 32'h33, 1'b0, 1'b0, 8'd2);
        tick();
        chk_all("bp_idle", 1'b0, 32'h33, 1'b0, 1'b0, 8'd2);

        // Protocol violation; err_clr coincident with the set loses.
        out_ready    = 1'b0;
        req_data     = 32'h1;
        req_tgl_sync = 1'b1;
        tick();
        chk_all("pv_first", 1'b1, 32'h1, 1'b0, 1'b0, 8'd2);
        req_data     = 32'h2;
        req_tgl_sync = 1'b0;
        err_clr      = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_all("pv_flag", 1'b1, 32'h1, 1'b0, 1'b1, 8'd2);
        out_ready = 1'b1;
        tick();
        chk_all("pv_hs", 1'b0, 32'h1, 1'b1, 1'b1, 8'd3);
        tick();
        chk_all("pv_pending", 1'b1, 32'h2, 1'b1, 1'b1, 8'd3);
        tick();
        chk_all("pv_hs2", 1'b0, 32'h2, 1'b0, 1'b1, 8'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("pv_clear", 64'(proto_err), 64'd0);

        // Wrap and back-to-back, starting from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("wrap_reset", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
        tg = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tg           = ~tg;
            req_tgl_sync = tg;
            req_data     = 32'(i) ^ 32'h5A00_0000;
            tick();
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_data",  64'(out_data),  64'(32'(i) ^ 32'h5A00_0000));
            tick();
            chk("b2b_idle",  64'(out_valid), 64'd0);
            chk("b2b_cnt",   64'(xfer_cnt),  64'((i + 1) % 256));
        end
        chk("wrap_cnt", 64'(xfer_cnt), 64'd0);
        chk("wrap_ack", 64'(ack_tgl),  64'd0);
        chk("wrap_err", 64'(proto_err), 64'd0);

        // Reset mid-transfer while stalled; toggle held high across reset.
        out_ready    = 1'b0;
        req_data     = 32'h77;
        req_tgl_sync = 1'b1;
        tick();
        chk_all("rm_hold", 1'b1, 32'h77, 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("rm_reset", 1'b0, 32'h0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_all("rm_rerequest", 1'b1, 32'h77, 1'b0, 1'b0, 8'd0);
        out_ready = 1'b1;
        tick();
        chk_all("rm_done", 1'b0, 32'h77, 1'b1, 1'b0, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
